// File: rtl/fxp_alu_sequencer_if.sv
// Start/busy/done bundle between the calculator FSM (master) and the fixed-point ALU (slave).
interface fxp_alu_sequencer_if #(
    parameter int WIDTH_ARG = 25,
    parameter int WIDTH_RES = 35
);
    logic                        start;
    logic [1:0]                  op;
    logic signed [WIDTH_RES-1:0] a;
    logic signed [WIDTH_ARG-1:0] b;
    logic                        busy;
    logic                        done;
    logic signed [WIDTH_RES-1:0] result;
    logic                        err;

    modport master (output start, op, a, b, input busy, done, result, err);
    modport slave  (input start, op, a, b, output busy, done, result, err);
endinterface

// File: rtl/fxp_alu_sequencer.sv
// Multi-cycle fixed-point ALU: add/sub in one step, multiply/divide as shift-add
// followed by restoring division, with a range check before the result is published.
module fxp_alu_sequencer #(
    parameter int WIDTH_ARG = 25,
    parameter int WIDTH_RES = 35,
    parameter int SCALE     = 1000,
    parameter int LIMIT_POS = 9999000,
    parameter int LIMIT_NEG = 999000
) (
    input logic             clk,
    input logic             rst,
    fxp_alu_sequencer_if.slave bus
);
    localparam int PW = WIDTH_RES + WIDTH_ARG;
    localparam int SW = WIDTH_RES + 2;
    localparam int CW = $clog2(PW + 1);
    localparam logic [1:0] OP_MINUS = 2'd1;
    localparam logic [1:0] OP_MUL   = 2'd2;
    localparam logic [1:0] OP_DIV   = 2'd3;

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, DIV, FIN} state_t;
    state_t state, state_next;

    logic [CW-1:0]        cnt;
    logic [1:0]           op_q;
    logic                 a_neg_q, b_neg_q, neg, div0;
    logic [WIDTH_RES-1:0] a_mag;
    logic [WIDTH_ARG-1:0] b_mag;
    logic [PW-1:0]        mcand, acc;
    logic [WIDTH_ARG-1:0] mplr, divisor, rem;

    logic [WIDTH_RES-1:0] a_raw, a_abs_in, res_mag;
    logic [WIDTH_ARG-1:0] b_raw, b_abs_in;
    logic signed [SW-1:0] a_s, b_s, sum_s;
    logic [SW-1:0]        sum_mag;
    logic [WIDTH_ARG:0]   trial, diff;
    logic                 ge, legal;

    always_comb begin
        a_raw    = bus.a;
        b_raw    = bus.b;
        a_abs_in = a_raw[WIDTH_RES-1] ? (~a_raw + WIDTH_RES'(1)) : a_raw;
        b_abs_in = b_raw[WIDTH_ARG-1] ? (~b_raw + WIDTH_ARG'(1)) : b_raw;
        a_s      = $signed({2'b00, a_mag});
        b_s      = $signed({{(SW-WIDTH_ARG){1'b0}}, b_mag});
        if (a_neg_q) a_s = -a_s;
        if (b_neg_q) b_s = -b_s;
        sum_s    = (op_q == OP_MINUS) ? (a_s - b_s) : (a_s + b_s);
        sum_mag  = sum_s[SW-1] ? SW'(-sum_s) : SW'(sum_s);
        trial    = {rem, acc[PW-1]};
        diff     = trial - {1'b0, divisor};
        ge       = (trial >= {1'b0, divisor});
        res_mag  = acc[WIDTH_RES-1:0];
        legal    = neg ? (acc <= PW'(LIMIT_NEG)) : (acc <= PW'(LIMIT_POS));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Divide-by-zero takes the short add/sub path so it finishes as fast as PLUS.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start)
                         state_next = (!bus.op[1] || (bus.op == OP_DIV && bus.b == '0)) ? ADDSUB : MUL;
            ADDSUB:  state_next = FIN;
            MUL:     if (cnt == CW'(WIDTH_ARG - 1)) state_next = DIV;
            DIV:     if (cnt == CW'(PW - 1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        case (state)
            IDLE: if (bus.start) begin
                op_q    <= bus.op;
                a_neg_q <= a_raw[WIDTH_RES-1];
                b_neg_q <= b_raw[WIDTH_ARG-1];
                a_mag   <= a_abs_in;
                b_mag   <= b_abs_in;
                neg     <= a_raw[WIDTH_RES-1] ^ b_raw[WIDTH_ARG-1];
                div0    <= (bus.op == OP_DIV) && (bus.b == '0);
                mcand   <= PW'(a_abs_in);
                mplr    <= (bus.op == OP_MUL) ? b_abs_in : WIDTH_ARG'(SCALE);
                divisor <= (bus.op == OP_MUL) ? WIDTH_ARG'(SCALE) : b_abs_in;
                acc     <= '0;
                rem     <= '0;
                cnt     <= '0;
            end
            ADDSUB: begin
                acc <= div0 ? '0 : PW'(sum_mag);
                neg <= div0 ? 1'b0 : sum_s[SW-1];
            end
            MUL: begin
                if (mplr[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                cnt   <= (cnt == CW'(WIDTH_ARG - 1)) ? '0 : cnt + CW'(1);
            end
            DIV: begin
                rem <= ge ? diff[WIDTH_ARG-1:0] : trial[WIDTH_ARG-1:0];
                acc <= {acc[PW-2:0], ge};
                cnt <= cnt + CW'(1);
            end
            default: ;
        endcase
    end

    assign bus.busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.err    <= 1'b0;
        end else begin
            bus.done <= (state == FIN);
            if (state == IDLE && bus.start) begin
                bus.result <= '0;
                bus.err    <= 1'b0;
            end else if (state == FIN) begin
                if (div0 || !legal) begin
                    bus.result <= '0;
                    bus.err    <= 1'b1;
                end else begin
                    bus.result <= neg ? -res_mag : res_mag;
                    bus.err    <= 1'b0;
                end
            end
        end
    end
endmodule
